// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Slave end of the CPU memory-stage data interface. Accepts a read or write
//   request from the M stage and services it from an internal word-organised
//   SRAM model after LATENCY cycles. While the access is in flight the
//   pipeline is held with stall.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   mem_read   read request
//   mem_write  write request (wins over mem_read when both are high)
//   addr       byte address, bits [1:0] ignored
//   wdata      lane-aligned write data
//   select     byte-lane write enables
//   rdata      read data, held until the next completed read
//   stall      pipeline hold while an accepted access is incomplete
//   addr_err   one-cycle pulse in the completion cycle of an out-of-range access
module data_mem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  select,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        addr_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int WORDS     = 1 << DEPTH_LOG2;
    localparam bit ONE_CYCLE = (LATENCY == 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Request fields captured at acceptance; the access uses these, not the
    // live inputs, so the CPU may change its outputs while stalled.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic        wr_q;

    logic [31:0] mem_q [WORDS];

    logic                  req;
    logic                  acc_wr;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_offset;
    logic                  acc_in_range;
    logic [DEPTH_LOG2-1:0] acc_index;
    logic                  do_access;

    assign req = mem_read | mem_write;

    // With LATENCY=1 the access happens on the accepting edge itself, so the
    // live inputs are the access source while in IDLE.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wr    = mem_write;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_sel   = select;
        end else begin
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_sel   = sel_q;
        end
    end

    // Unsigned wraparound subtraction: addresses below BASE_ADDR wrap to a
    // large offset and therefore land out of range.
    assign acc_offset   = acc_addr - BASE_ADDR;
    assign acc_in_range = ((acc_offset >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign acc_index    = acc_offset[DEPTH_LOG2+1:2];

    assign do_access = rst &
                       ((ONE_CYCLE && (state_q == S_IDLE) && req) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = ONE_CYCLE ? S_DONE : S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            // Completion cycle: a req still high here is the finished access.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (do_access) begin
            err_d = ~acc_in_range;
            if (!acc_wr) begin
                rdata_d = acc_in_range ? mem_q[acc_index] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture registers and the array carry no reset; array contents survive
    // reset and an uncommitted write is simply never performed.
    always_ff @(posedge clk) begin
        if ((state_q == S_IDLE) && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            sel_q   <= select;
            wr_q    <= mem_write;
        end
        if (do_access && acc_wr && acc_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    mem_q[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Reset forces stall low immediately even if a request is still presented.
    assign stall    = rst & (((state_q == S_IDLE) & req) | (state_q == S_WAIT));
    assign rdata    = rdata_q;
    assign addr_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Three instances with LATENCY 2, 1 and 4
// each get their own request bus; a shared clock and reset drive all three.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        rd_s  [3];
    logic        wr_s  [3];
    logic [31:0] a_s   [3];
    logic [31:0] wd_s  [3];
    logic [3:0]  sel_s [3];
    logic [31:0] rdata_w [3];
    logic        stall_w [3];
    logic        err_w   [3];

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h0)) u_lat2 (
        .clk(clk), .rst(rst), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
        .addr(a_s[0]), .wdata(wd_s[0]), .select(sel_s[0]),
        .rdata(rdata_w[0]), .stall(stall_w[0]), .addr_err(err_w[0]));

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .clk(clk), .rst(rst), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
        .addr(a_s[1]), .wdata(wd_s[1]), .select(sel_s[1]),
        .rdata(rdata_w[1]), .stall(stall_w[1]), .addr_err(err_w[1]));

    data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .BASE_ADDR(32'h0)) u_lat4 (
        .clk(clk), .rst(rst), .mem_read(rd_s[2]), .mem_write(wr_s[2]),
        .addr(a_s[2]), .wdata(wd_s[2]), .select(sel_s[2]),
        .rdata(rdata_w[2]), .stall(stall_w[2]), .addr_err(err_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int          id;
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic int lat_of(input int id);
        return (id == 0) ? 2 : (id == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_bus(input int id);
        rd_s[id]  = 1'b0;
        wr_s[id]  = 1'b0;
        a_s[id]   = 32'd0;
        wd_s[id]  = 32'd0;
        sel_s[id] = 4'd0;
    endtask

    // Entered just after a rising edge with the instance idle. Request is held
    // through the DONE cycle, as the stalled CPU would do, and dropped in the
    // following idle cycle where the next access may start at once.
    task automatic access(input vec_t v);
        int id;
        id = v.id;
        rd_s[id]  = v.rd;
        wr_s[id]  = v.wr;
        a_s[id]   = v.a;
        wd_s[id]  = v.wd;
        sel_s[id] = v.sel;
        for (int k = 0; k < lat_of(id); k++) begin
            @(negedge clk);
            chk("stall_busy", 32'(stall_w[id]), 32'd1);
            chk("err_busy", 32'(err_w[id]), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("stall_done", 32'(stall_w[id]), 32'd0);
        chk("addr_err_done", 32'(err_w[id]), 32'(v.exp_err));
        chk("rdata_done", rdata_w[id], v.exp_rd);
        @(posedge clk);
        #1;
        clear_bus(id);
        chk("addr_err_pulse_end", 32'(err_w[id]), 32'd0);
        chk("rdata_hold", rdata_w[id], v.exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) clear_bus(i);
        rst = 1'b0;

        // Reset held for three cycles, then idle with no requests.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("reset_rdata", rdata_w[i], 32'd0);
                chk("reset_stall", 32'(stall_w[i]), 32'd0);
                chk("reset_err", 32'(err_w[i]), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("idle_rdata", rdata_w[i], 32'd0);
                chk("idle_stall", 32'(stall_w[i]), 32'd0);
                chk("idle_err", 32'(err_w[i]), 32'd0);
            end
        end
        @(posedge clk);
        #1;

        //              id wr rd addr           wdata          sel      exp_rdata      err
        vecs.push_back('{0, 1, 0, 32'h0000_0000, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b0});
        vecs.push_back('{0, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0});
        vecs.push_back('{0, 0, 1, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 1, 0, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 1, 0, 32'h0000_0020, 32'h00AA_0000, 4'b0100, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{0, 0, 1, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h11AA_3344, 1'b0});
        vecs.push_back('{0, 1, 0, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h11AA_3344, 1'b0});
        vecs.push_back('{0, 0, 1, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h11AA_3344, 1'b0});
        vecs.push_back('{0, 1, 0, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h11AA_3344, 1'b1});
        vecs.push_back('{0, 0, 1, 32'h0000_1000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{0, 0, 1, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{0, 1, 0, 32'h0000_0FFC, 32'hA5A5_0FFC, 4'b1111, 32'h0000_0000, 1'b0});
        vecs.push_back('{0, 0, 1, 32'h0000_0FFC, 32'h0000_0000, 4'b0000, 32'hA5A5_0FFC, 1'b0});
        vecs.push_back('{0, 1, 1, 32'h0000_0024, 32'h5566_7788, 4'b1111, 32'hA5A5_0FFC, 1'b0});
        vecs.push_back('{0, 0, 1, 32'h0000_0027, 32'h0000_0000, 4'b0000, 32'h5566_7788, 1'b0});
        vecs.push_back('{0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1});
        // LATENCY=1, issued back to back with no idle gaps between accesses
        vecs.push_back('{1, 1, 0, 32'h0000_0010, 32'h0102_0304, 4'b1111, 32'h0000_0000, 1'b0});
        vecs.push_back('{1, 0, 1, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h0102_0304, 1'b0});
        vecs.push_back('{1, 1, 0, 32'h0000_0014, 32'h0BAD_C0DE, 4'b1111, 32'h0102_0304, 1'b0});
        vecs.push_back('{1, 0, 1, 32'h0000_0014, 32'h0000_0000, 4'b0000, 32'h0BAD_C0DE, 1'b0});
        // LATENCY=4, seed 0x30 with zero before the interrupted write
        vecs.push_back('{2, 1, 0, 32'h0000_0030, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b0});

        foreach (vecs[i]) access(vecs[i]);

        // Inputs changed during WAIT must not affect the captured access.
        rd_s[0] = 1'b0; wr_s[0] = 1'b1; a_s[0] = 32'h28; wd_s[0] = 32'h7777_8888; sel_s[0] = 4'hF;
        @(negedge clk);
        chk("capture_stall_t0", 32'(stall_w[0]), 32'd1);
        @(posedge clk);
        #1;
        a_s[0] = 32'h2C; wd_s[0] = 32'h9999_0000; wr_s[0] = 1'b0; rd_s[0] = 1'b0;
        @(negedge clk);
        chk("capture_stall_wait", 32'(stall_w[0]), 32'd1);
        @(posedge clk);
        #1;
        clear_bus(0);
        @(negedge clk);
        chk("capture_stall_done", 32'(stall_w[0]), 32'd0);
        @(posedge clk);
        #1;
        access('{0, 0, 1, 32'h0000_0028, 32'h0, 4'h0, 32'h7777_8888, 1'b0});

        // Reset in the second WAIT cycle of a LATENCY=4 write.
        wr_s[2] = 1'b1; a_s[2] = 32'h30; wd_s[2] = 32'hCAFE_F00D; sel_s[2] = 4'hF;
        @(negedge clk);
        chk("rst_mid_stall_t0", 32'(stall_w[2]), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_mid_stall_wait2", 32'(stall_w[2]), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_stall_async", 32'(stall_w[2]), 32'd0);
        chk("rst_mid_rdata_lat2", rdata_w[0], 32'd0);
        clear_bus(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        access('{2, 0, 1, 32'h0000_0030, 32'h0, 4'h0, 32'h0000_0000, 1'b0});
        // Array contents survive reset.
        access('{0, 0, 1, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
